// File: rtl/ram_burst_reader.sv
// Read-side burst engine for ram_2nxm: walks a contiguous (wrapping) address range and
// streams the words over valid/ready with a last flag and a running modular checksum.
module ram_burst_reader #(
   parameter int N = 6,
   parameter int M = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] base_adr,
   input  logic [N:0]   len,
   output logic         busy,
   output logic         done,
   output logic [M-1:0] checksum,
   output logic [N-1:0] ram_adr,
   input  logic [M-1:0] ram_dout,
   output logic         ram_we,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [M-1:0] out_data,
   output logic         out_last
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

   localparam logic [N:0] LEN_ONE = (N+1)'(1);

   state_t     state, state_next;
   logic [N:0] remaining;
   logic       accept;
   logic       load;
   logic       handshake;

   assign handshake = out_valid && out_ready;
   assign busy      = (state == READ) || (state == DRAIN);
   assign done      = (state == FIN);
   assign ram_we    = 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // The output register refills whenever it is empty or its word is being taken.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = (len == '0) ? FIN : READ;
            end
         end
         READ: begin
            if (!out_valid || out_ready) begin
               load = 1'b1;
               if (remaining == LEN_ONE) state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (handshake) state_next = FIN;
         end
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_adr   <= '0;
         remaining <= '0;
         checksum  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (accept) begin
         ram_adr   <= base_adr;
         remaining <= len;
         checksum  <= '0;
      end else if (load) begin
         out_data  <= ram_dout;
         out_valid <= 1'b1;
         out_last  <= (remaining == LEN_ONE);
         ram_adr   <= ram_adr + N'(1);
         remaining <= remaining - LEN_ONE;
         checksum  <= checksum + ram_dout;
      end else if (state == DRAIN && handshake) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a combinational RAM model preloaded mem[i]=i+100.
module tb_ram_burst_reader;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [5:0]  base_adr;
   logic [6:0]  len;
   logic        busy;
   logic        done;
   logic [31:0] checksum;
   logic [5:0]  ram_adr;
   logic [31:0] ram_dout;
   logic        ram_we;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;

   logic [31:0] mem [64];
   int checks = 0;
   int errors = 0;

   ram_burst_reader #(.N(6), .M(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_adr(base_adr), .len(len),
      .busy(busy), .done(done), .checksum(checksum), .ram_adr(ram_adr),
      .ram_dout(ram_dout), .ram_we(ram_we), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
   );

   assign ram_dout = mem[ram_adr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; base_adr = '0; len = '0; out_ready = 1'b1;
      cyc(); cyc();
      checks++;
      if ({busy, done, out_valid, out_last, ram_we} !== 5'b0) begin
         errors++; $display("[TB] FAIL reset_flags: got %b expected 00000", {busy, done, out_valid, out_last, ram_we});
      end
      checks++;
      if ({ram_adr, out_data, checksum} !== 70'b0) begin
         errors++; $display("[TB] FAIL reset_regs: adr=%0d data=%0d sum=%0d expected all 0", ram_adr, out_data, checksum);
      end
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_basic();
      cyc();
      start = 1'b1; base_adr = 6'd4; len = 7'd3; out_ready = 1'b1;
      cyc();
      start = 1'b0;
      checks++;
      if ({busy, done, out_valid, ram_adr} !== {3'b100, 6'd4}) begin
         errors++; $display("[TB] FAIL basic_cycle1: busy/done/valid=%b adr=%0d expected 100 adr=4", {busy, done, out_valid}, ram_adr);
      end
      for (int k = 0; k < 3; k++) begin
         cyc();
         checks++;
         if ({busy, done, out_valid, out_last, out_data} !== {3'b101, (k == 2), 32'(104 + k)}) begin
            errors++; $display("[TB] FAIL basic_beat%0d: flags=%b data=%0d expected flags=101%0d data=%0d",
                               k, {busy, done, out_valid, out_last}, out_data, (k == 2), 104 + k);
         end
      end
      cyc();
      checks++;
      if ({busy, done, out_valid, checksum} !== {3'b010, 32'd315}) begin
         errors++; $display("[TB] FAIL basic_done: flags=%b sum=%0d expected 010 sum=315", {busy, done, out_valid}, checksum);
      end
      cyc();
      checks++;
      if ({busy, done} !== 2'b00) begin
         errors++; $display("[TB] FAIL basic_after: busy/done=%b expected 00", {busy, done});
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp [4];
      exp = '{32'd162, 32'd163, 32'd100, 32'd101};
      cyc();
      start = 1'b1; base_adr = 6'd62; len = 7'd4; out_ready = 1'b1;
      cyc();
      start = 1'b0;
      checks++;
      if (ram_adr !== 6'd62) begin
         errors++; $display("[TB] FAIL wrap_adr0: got %0d expected 62", ram_adr);
      end
      for (int k = 0; k < 4; k++) begin
         cyc();
         checks++;
         if ({out_valid, out_last, out_data} !== {1'b1, (k == 3), exp[k]}) begin
            errors++; $display("[TB] FAIL wrap_beat%0d: valid=%b last=%b data=%0d expected data=%0d",
                               k, out_valid, out_last, out_data, exp[k]);
         end
      end
      cyc();
      checks++;
      if ({done, checksum, ram_adr} !== {1'b1, 32'd526, 6'd2}) begin
         errors++; $display("[TB] FAIL wrap_done: done=%b sum=%0d adr=%0d expected 1 526 2", done, checksum, ram_adr);
      end
   endtask

   task automatic test_backpressure();
      logic pat [8];
      int   idx;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      idx = 0;
      cyc();
      start = 1'b1; base_adr = 6'd10; len = 7'd4; out_ready = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         cyc();
         start = 1'b0;
         out_ready = pat[c-1];
         if (c >= 2) begin
            checks++;
            if ({done, out_valid, out_last, out_data} !== {2'b01, (idx == 3), 32'(110 + idx)}) begin
               errors++; $display("[TB] FAIL bp_cycle%0d: done=%b valid=%b last=%b data=%0d expected 0 1 %0d data=%0d",
                                  c, done, out_valid, out_last, out_data, (idx == 3), 110 + idx);
            end
            if (out_ready) idx++;
         end
      end
      out_ready = 1'b1;
      checks++;
      if (idx !== 4) begin
         errors++; $display("[TB] FAIL bp_count: got %0d handshakes expected 4", idx);
      end
      cyc();
      checks++;
      if ({done, busy, out_valid, checksum} !== {3'b100, 32'd446}) begin
         errors++; $display("[TB] FAIL bp_done: done/busy/valid=%b sum=%0d expected 100 446", {done, busy, out_valid}, checksum);
      end
   endtask

   task automatic test_zero_len();
      cyc();
      start = 1'b1; base_adr = 6'd20; len = 7'd0;
      cyc();
      start = 1'b0;
      checks++;
      if ({done, busy, out_valid, checksum} !== {3'b100, 32'd0}) begin
         errors++; $display("[TB] FAIL zero_done: done/busy/valid=%b sum=%0d expected 100 0", {done, busy, out_valid}, checksum);
      end
      cyc();
      checks++;
      if ({done, busy, out_valid} !== 3'b000) begin
         errors++; $display("[TB] FAIL zero_after: done/busy/valid=%b expected 000", {done, busy, out_valid});
      end
   endtask

   task automatic test_ignore_start();
      cyc();
      start = 1'b1; base_adr = 6'd30; len = 7'd3; out_ready = 1'b1;
      cyc();
      base_adr = 6'd50; len = 7'd5;
      checks++;
      if ({busy, ram_adr} !== {1'b1, 6'd30}) begin
         errors++; $display("[TB] FAIL ign_cycle1: busy=%b adr=%0d expected 1 30", busy, ram_adr);
      end
      for (int k = 0; k < 3; k++) begin
         cyc();
         checks++;
         if ({out_valid, out_last, out_data} !== {1'b1, (k == 2), 32'(130 + k)}) begin
            errors++; $display("[TB] FAIL ign_beat%0d: valid=%b last=%b data=%0d expected data=%0d",
                               k, out_valid, out_last, out_data, 130 + k);
         end
      end
      cyc();
      checks++;
      if ({done, checksum} !== {1'b1, 32'd393}) begin
         errors++; $display("[TB] FAIL ign_done: done=%b sum=%0d expected 1 393", done, checksum);
      end
      cyc();
      start = 1'b0;
      checks++;
      if ({busy, done, checksum, ram_adr} !== {2'b00, 32'd393, 6'd33}) begin
         errors++; $display("[TB] FAIL ign_fin_start: busy/done=%b sum=%0d adr=%0d expected 00 393 33",
                            {busy, done}, checksum, ram_adr);
      end
   endtask

   task automatic test_full_length();
      cyc();
      start = 1'b1; base_adr = 6'd5; len = 7'd64; out_ready = 1'b1;
      cyc();
      start = 1'b0;
      for (int k = 0; k < 64; k++) begin
         cyc();
         checks++;
         if ({out_valid, out_last, out_data} !== {1'b1, (k == 63), 32'(((5 + k) % 64) + 100)}) begin
            errors++; $display("[TB] FAIL full_beat%0d: valid=%b last=%b data=%0d expected data=%0d",
                               k, out_valid, out_last, out_data, ((5 + k) % 64) + 100);
         end
      end
      cyc();
      checks++;
      if ({done, busy, checksum, ram_adr} !== {2'b10, 32'd8416, 6'd5}) begin
         errors++; $display("[TB] FAIL full_done: done/busy=%b sum=%0d adr=%0d expected 10 8416 5",
                            {done, busy}, checksum, ram_adr);
      end
   endtask

   task automatic test_async_reset();
      cyc();
      start = 1'b1; base_adr = 6'd4; len = 7'd3; out_ready = 1'b1;
      cyc();
      start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         cyc();
         checks++;
         if (out_data !== 32'(104 + k)) begin
            errors++; $display("[TB] FAIL arst_beat%0d: data=%0d expected %0d", k, out_data, 104 + k);
         end
      end
      cyc();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, out_valid, out_last, ram_adr, out_data, checksum} !== 74'b0) begin
         errors++; $display("[TB] FAIL arst_immediate: flags=%b adr=%0d data=%0d sum=%0d expected all 0",
                            {busy, done, out_valid, out_last}, ram_adr, out_data, checksum);
      end
      cyc();
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         checks++;
         if ({done, busy, out_valid} !== 3'b000) begin
            errors++; $display("[TB] FAIL arst_quiet%0d: done/busy/valid=%b expected 000", k, {done, busy, out_valid});
         end
      end
      test_basic();
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'(i + 100);
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_zero_len();
      test_ignore_start();
      test_full_length();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
